mmc1_mapper: RTL and testbench
==============================

# mmc1_mapper

MMC1-compatible mapper controller that sits between the CPU/PPU buses and the cartridge PRG/CHR ROMs, replacing the fixed NROM mapping. It decodes CPU writes to $8000-$FFFF through a 5-bit serial loader into four configuration registers. From those registers it combinationally produces banked PRG/CHR ROM addresses, PRG-RAM select, nametable mirroring (vram_cs/vram_a10) and a tied-off irq.

## Interface
- PRG_BANKS, 16, number of 16 KB PRG banks; power of two, 2..16
- CHR_BANKS, 32, number of 4 KB CHR banks; power of two, 2..32
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_en  in  1  CPU cycle enable; bus write sampled only when high
- prg_addr  in  16  CPU address
- prg_wdata  in  8  CPU write data
- prg_write  in  1  CPU write strobe
- chr_addr  in  14  PPU address
- prg_rom_addr  out  18  byte address into PRG ROM
- prg_ram_cs  out  1  PRG-RAM select ($6000-$7FFF and RAM enabled)
- chr_rom_addr  out  17  byte address into CHR ROM
- irq  out  1  constant 0
- vram_cs  out  1  chr_addr[13]
- vram_a10  out  1  nametable select per mirroring mode

## Operation
- Registers: control[4:0], chr0[4:0], chr1[4:0], prg[4:0], shift[4:0], count[2:0], last_wr (1 bit).
- Valid write: cpu_en & prg_write & prg_addr[15] & ~last_wr.
- last_wr <= prg_write & prg_addr[15] on every cpu_en cycle; unchanged otherwise. A write on the cpu_en cycle directly after a $8000+ write is ignored (RMW protection).
- Valid write with wdata[7]=1: shift<=0, count<=0, control<=control|5'h0C.
- Valid write with wdata[7]=0 and count<4: shift<={wdata[0],shift[4:1]}; count<=count+1.
- Valid write with wdata[7]=0 and count==4: value={wdata[0],shift[4:1]}.
  - Destination by prg_addr[14:13]: 0 control, 1 chr0, 2 chr1, 3 prg.
  - shift<=0, count<=0.
- Mirroring, control[1:0]:
  - 0: vram_a10=0
  - 1: vram_a10=1
  - 2 (vertical): vram_a10=chr_addr[10]
  - 3 (horizontal): vram_a10=chr_addr[11]
- PRG mapping, control[3:2], bank b, offset prg_addr[13:0]:
  - 0/1 (32 KB mode): b={prg[3:1],prg_addr[14]}
  - 2: $8000 -> bank 0; $C000 -> prg[3:0]
  - 3: $8000 -> prg[3:0]; $C000 -> PRG_BANKS-1
- prg_rom_addr={b & (PRG_BANKS-1), offset}, zero-extended to 18 bits.
- prg_ram_cs=(prg_addr[15:13]==3'b011) & ~prg[4].
- CHR mapping, 4 KB bank c, offset chr_addr[11:0]:
  - control[4]=0 (8 KB mode): c={chr0[4:1],chr_addr[12]}
  - control[4]=1 (4 KB mode): c = chr_addr[12] ? chr1 : chr0
- chr_rom_addr={c & (CHR_BANKS-1), offset}.
- Reads, and writes below $8000, leave all state unchanged.

## Timing
- Reset values: control=5'h0C, chr0=chr1=prg=0, shift=0, count=0, last_wr=0.
- Output values after reset:
  - prg_rom_addr maps $C000 to the last bank, $8000 to bank 0.
  - prg_ram_cs is active for $6000-$7FFF.
  - vram_a10=0, irq=0.
- All outputs are combinational from registers and current addresses; no added latency.
- Register updates occur on the clk edge of the valid-write cycle; the new mapping is visible the following cycle.
- Reset has priority over a simultaneous write. Reset mid-sequence discards the partial shift.
- A bit-7 write landing on the 5th write takes the clear path; no register is loaded.
- A write with cpu_en=0 has no effect, including on last_wr.

## Structure
- Package mmc1_pkg:
  - mirroring enum (ONE_LO, ONE_HI, VERT, HORZ)
  - PRG mode constants
  - CONTROL_RESET=5'h0C
  - register-select encoding
- Sub-module mmc1_serial_loader: owns shift, count and last_wr. Outputs load strobe, 2-bit select, 5-bit value and clear_ctrl strobe.
- Bank decode stays in the top module.

## Test plan
- Reset, then drive $8000 and $C000 -> prg_rom_addr 0x00000 and 0x3C000; read $6000 -> prg_ram_cs=1; vram_a10=0.
- Five writes to $E000 (one per cpu_en cycle, cpu_en=0 cycle between each) with bit0 = 1,1,0,0,0 -> prg=3; drive $8123 -> prg_rom_addr 0x0C123.
- Control=5'h10, chr0=5, chr1=9; drive chr_addr 0x1234 -> chr_rom_addr 0x09234; drive 0x0234 -> 0x05234.
- Two shift writes, then 0x80 to $8000 -> count=0, control[3:2]=3; five more writes load cleanly.
- Two $8000 writes on back-to-back cpu_en cycles -> second ignored, count advances by 1.
- Control=2: chr_addr 0x2400 -> vram_a10=1. Control=3: chr_addr 0x2400 -> 0, 0x2800 -> 1. Reset after 3 shifts -> count=0.

Source files
------------

// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1-compatible mapper: mirroring modes,
// PRG banking modes, control reset value and serial-register destinations.
package mmc1_pkg;

  typedef enum logic [1:0] {
    ONE_LO = 2'd0,
    ONE_HI = 2'd1,
    VERT   = 2'd2,
    HORZ   = 2'd3
  } mirror_e;

  // control[3:2]: modes 0 and 1 both switch 32 KB at a time
  localparam logic [1:0] PRG_MODE_32K_A  = 2'd0;
  localparam logic [1:0] PRG_MODE_32K_B  = 2'd1;
  localparam logic [1:0] PRG_MODE_FIX_LO = 2'd2;
  localparam logic [1:0] PRG_MODE_FIX_HI = 2'd3;

  localparam logic [4:0] CONTROL_RESET = 5'h0C;

  // Destination chosen by prg_addr[14:13] on the fifth serial write
  typedef enum logic [1:0] {
    SEL_CONTROL = 2'd0,
    SEL_CHR0    = 2'd1,
    SEL_CHR1    = 2'd2,
    SEL_PRG     = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/mmc1_serial_loader.sv
// Five-write serial loader: collects bit 0 of CPU writes to $8000-$FFFF and
// emits a load strobe with the assembled value, or a clear strobe on bit 7.
module mmc1_serial_loader
  import mmc1_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       write,
  input  logic       addr_hi,
  input  logic [1:0] addr_sel,
  input  logic       data_clear,
  input  logic       data_bit,
  output logic       load,
  output logic [1:0] load_sel,
  output logic [4:0] load_value,
  output logic       clear_ctrl
);

  logic [4:0] shift;
  logic [2:0] count;
  logic       last_wr;
  logic       valid_wr;

  // A write on the cpu_en cycle right after a $8000+ write is dropped, so a
  // read-modify-write instruction only shifts in one bit.
  assign valid_wr   = cpu_en & write & addr_hi & ~last_wr;
  assign clear_ctrl = valid_wr & data_clear;
  assign load       = valid_wr & ~data_clear & (count == 3'd4);
  assign load_sel   = addr_sel;
  assign load_value = {data_bit, shift[4:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      shift   <= '0;
      count   <= '0;
      last_wr <= 1'b0;
    end else if (cpu_en) begin
      last_wr <= write & addr_hi;
      if (valid_wr) begin
        if (data_clear || count == 3'd4) begin
          shift <= '0;
          count <= '0;
        end else begin
          shift <= {data_bit, shift[4:1]};
          count <= count + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mmc1_mapper.sv
// MMC1-compatible mapper: serial-loaded configuration registers and the
// combinational PRG/CHR bank decode, PRG-RAM select and nametable mirroring.
module mmc1_mapper
  import mmc1_pkg::*;
#(
  parameter int PRG_BANKS = 16,
  parameter int CHR_BANKS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [15:0] prg_addr,
  input  logic [7:0]  prg_wdata,
  input  logic        prg_write,
  input  logic [13:0] chr_addr,
  output logic [17:0] prg_rom_addr,
  output logic        prg_ram_cs,
  output logic [16:0] chr_rom_addr,
  output logic        irq,
  output logic        vram_cs,
  output logic        vram_a10
);

  localparam logic [3:0] PRG_MASK = 4'(PRG_BANKS - 1);
  localparam logic [4:0] CHR_MASK = 5'(CHR_BANKS - 1);
  localparam logic [3:0] PRG_LAST = 4'(PRG_BANKS - 1);

  logic [4:0] control;
  logic [4:0] chr0;
  logic [4:0] chr1;
  logic [4:0] prg;

  logic       load;
  logic [1:0] load_sel;
  logic [4:0] load_value;
  logic       clear_ctrl;
  logic       unused_wdata;

  logic [3:0] prg_bank;
  logic [4:0] chr_bank;
  mirror_e    mirror;

  // Only bits 7 and 0 of the write data carry meaning for the serial port.
  assign unused_wdata = ^prg_wdata[6:1];

  mmc1_serial_loader u_loader (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .write      (prg_write),
    .addr_hi    (prg_addr[15]),
    .addr_sel   (prg_addr[14:13]),
    .data_clear (prg_wdata[7]),
    .data_bit   (prg_wdata[0]),
    .load       (load),
    .load_sel   (load_sel),
    .load_value (load_value),
    .clear_ctrl (clear_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      control <= CONTROL_RESET;
      chr0    <= '0;
      chr1    <= '0;
      prg     <= '0;
    end else if (clear_ctrl) begin
      control <= control | CONTROL_RESET;
    end else if (load) begin
      case (reg_sel_e'(load_sel))
        SEL_CONTROL: control <= load_value;
        SEL_CHR0:    chr0    <= load_value;
        SEL_CHR1:    chr1    <= load_value;
        default:     prg     <= load_value;
      endcase
    end
  end

  always_comb begin
    prg_bank = '0;
    case (control[3:2])
      PRG_MODE_FIX_LO: prg_bank = prg_addr[14] ? prg[3:0] : 4'd0;
      PRG_MODE_FIX_HI: prg_bank = prg_addr[14] ? PRG_LAST : prg[3:0];
      default:         prg_bank = {prg[3:1], prg_addr[14]};
    endcase
  end

  always_comb begin
    chr_bank = '0;
    if (control[4]) chr_bank = chr_addr[12] ? chr1 : chr0;
    else            chr_bank = {chr0[4:1], chr_addr[12]};
  end

  assign mirror = mirror_e'(control[1:0]);

  always_comb begin
    vram_a10 = 1'b0;
    case (mirror)
      ONE_LO:  vram_a10 = 1'b0;
      ONE_HI:  vram_a10 = 1'b1;
      VERT:    vram_a10 = chr_addr[10];
      default: vram_a10 = chr_addr[11];
    endcase
  end

  assign prg_rom_addr = {prg_bank & PRG_MASK, prg_addr[13:0]};
  assign chr_rom_addr = {chr_bank & CHR_MASK, chr_addr[11:0]};
  assign prg_ram_cs   = (prg_addr[15:13] == 3'b011) & ~prg[4];
  assign vram_cs      = chr_addr[13];
  assign irq          = 1'b0;

endmodule

// File: tb/tb_mmc1_mapper.sv
// Self-checking bench for mmc1_mapper: directed scenarios plus randomized bus
// traffic compared against an arithmetic model of the mapper's rules.
module tb_mmc1_mapper;

  localparam int PRG_BANKS = 16;
  localparam int CHR_BANKS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic [15:0] prg_addr;
  logic [7:0]  prg_wdata;
  logic        prg_write;
  logic [13:0] chr_addr;
  logic [17:0] prg_rom_addr;
  logic        prg_ram_cs;
  logic [16:0] chr_rom_addr;
  logic        irq;
  logic        vram_cs;
  logic        vram_a10;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_control, m_chr0, m_chr1, m_prg;
  int m_last_wr;
  int bits_q[$];

  mmc1_mapper #(.PRG_BANKS(PRG_BANKS), .CHR_BANKS(CHR_BANKS)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_en       (cpu_en),
    .prg_addr     (prg_addr),
    .prg_wdata    (prg_wdata),
    .prg_write    (prg_write),
    .chr_addr     (chr_addr),
    .prg_rom_addr (prg_rom_addr),
    .prg_ram_cs   (prg_ram_cs),
    .chr_rom_addr (chr_rom_addr),
    .irq          (irq),
    .vram_cs      (vram_cs),
    .vram_a10     (vram_a10)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic model_step();
    int a, v, dest;
    bit hit, valid;
    a = int'(prg_addr);
    if (reset) begin
      m_control = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
      m_last_wr = 0;
      bits_q.delete();
    end else if (cpu_en) begin
      hit   = prg_write && (a >= 32768);
      valid = hit && (m_last_wr == 0);
      m_last_wr = hit ? 1 : 0;
      if (valid) begin
        if (prg_wdata >= 8'd128) begin
          bits_q.delete();
          if ((m_control / 4) % 4 != 3) m_control = m_control + 12 - ((m_control / 4) % 4) * 4;
        end else begin
          bits_q.push_back(int'(prg_wdata) % 2);
          if (bits_q.size() == 5) begin
            v = 0;
            for (int i = 0; i < 5; i++) v += bits_q[i] * (1 << i);
            dest = (a / 8192) % 4;
            if (dest == 0) m_control = v;
            else if (dest == 1) m_chr0 = v;
            else if (dest == 2) m_chr1 = v;
            else m_prg = v;
            bits_q.delete();
          end
        end
      end
    end
  endtask

  function automatic int exp_prg(input int a);
    int mode, hi, bank;
    mode = (m_control / 4) % 4;
    hi   = (a / 16384) % 2;
    if (mode < 2)       bank = ((m_prg % 16) / 2) * 2 + hi;
    else if (mode == 2) bank = hi ? (m_prg % 16) : 0;
    else                bank = hi ? (PRG_BANKS - 1) : (m_prg % 16);
    return (bank % PRG_BANKS) * 16384 + a % 16384;
  endfunction

  function automatic int exp_chr(input int c);
    int bank;
    if (m_control >= 16) bank = ((c / 4096) % 2) ? m_chr1 : m_chr0;
    else                 bank = (m_chr0 / 2) * 2 + (c / 4096) % 2;
    return (bank % CHR_BANKS) * 4096 + c % 4096;
  endfunction

  function automatic int exp_a10(input int c);
    case (m_control % 4)
      0: return 0;
      1: return 1;
      2: return (c / 1024) % 2;
      default: return (c / 2048) % 2;
    endcase
  endfunction

  function automatic int exp_ram(input int a);
    return ((a / 8192) == 3 && m_prg < 16) ? 1 : 0;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_prg_rom"}, 32'(prg_rom_addr), exp_prg(int'(prg_addr)));
    check({tag, "_ram_cs"},  32'(prg_ram_cs),   exp_ram(int'(prg_addr)));
    check({tag, "_chr_rom"}, 32'(chr_rom_addr), exp_chr(int'(chr_addr)));
    check({tag, "_a10"},     32'(vram_a10),     exp_a10(int'(chr_addr)));
    check({tag, "_vram_cs"}, 32'(vram_cs),      (int'(chr_addr) / 8192) % 2);
    check({tag, "_irq"},     32'(irq),          0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // A write, a non-writing cpu_en cycle (clears the RMW guard), then an idle cycle
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    cpu_en = 1'b1; prg_write = 1'b1; prg_addr = a; prg_wdata = d;
    tick();
    prg_write = 1'b0;
    tick();
    cpu_en = 1'b0;
    tick();
  endtask

  task automatic load_reg(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) bus_write(a, {7'd0, v[i]});
  endtask

  task automatic probe(input logic [15:0] a, input logic [13:0] c, input string tag);
    cpu_en = 1'b0; prg_write = 1'b0; prg_addr = a; chr_addr = c;
    tick();
    check_model(tag);
  endtask

  initial begin
    reset = 1'b1; cpu_en = 1'b0; prg_write = 1'b0;
    prg_addr = '0; prg_wdata = '0; chr_addr = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    probe(16'h8000, 14'h2400, "rst8000");
    check("rst_prg_8000", 32'(prg_rom_addr), 32'h00000);
    check("rst_vram_a10", 32'(vram_a10), 0);
    check("rst_vram_cs", 32'(vram_cs), 1);
    check("rst_irq", 32'(irq), 0);
    probe(16'hC000, 14'h0000, "rstC000");
    check("rst_prg_C000", 32'(prg_rom_addr), 32'h3C000);
    probe(16'h6000, 14'h0000, "rst6000");
    check("rst_ram_cs_6000", 32'(prg_ram_cs), 1);
    probe(16'h5FFF, 14'h0000, "rst5FFF");
    check("ram_cs_5FFF", 32'(prg_ram_cs), 0);

    // prg = 3 in fixed-high mode
    load_reg(16'hE000, 5'd3);
    probe(16'h8123, 14'h0000, "prg3");
    check("prg3_8123", 32'(prg_rom_addr), 32'h0C123);

    // 4 KB CHR mode with chr0=5, chr1=9
    load_reg(16'h8000, 5'h10);
    load_reg(16'hA000, 5'd5);
    load_reg(16'hC000, 5'd9);
    probe(16'h8000, 14'h1234, "chr4k_hi");
    check("chr_1234", 32'(chr_rom_addr), 32'h09234);
    probe(16'h8000, 14'h0234, "chr4k_lo");
    check("chr_0234", 32'(chr_rom_addr), 32'h05234);

    // Bit-7 clear mid-sequence, then a clean five-write load
    bus_write(16'h8000, 8'h01);
    bus_write(16'h8000, 8'h01);
    bus_write(16'h8000, 8'h80);
    probe(16'hC000, 14'h0000, "clearC000");
    check("clear_prg_C000", 32'(prg_rom_addr), 32'h3C000);
    probe(16'h8000, 14'h0000, "clear8000");
    check("clear_prg_8000", 32'(prg_rom_addr), 32'h0C000);
    load_reg(16'h8000, 5'd2);
    probe(16'h8000, 14'h2400, "vert");
    check("vert_a10_2400", 32'(vram_a10), 1);
    check("mode32k_8000", 32'(prg_rom_addr), 32'h08000);

    // Back-to-back writes: second is dropped
    cpu_en = 1'b1; prg_write = 1'b1; prg_addr = 16'h8000; prg_wdata = 8'h01;
    tick();
    prg_wdata = 8'h00;
    tick();
    prg_write = 1'b0;
    tick();
    cpu_en = 1'b0;
    tick();
    bus_write(16'h8000, 8'h01);
    bus_write(16'h8000, 8'h00);
    bus_write(16'h8000, 8'h00);
    bus_write(16'h8000, 8'h00);
    probe(16'h8000, 14'h2400, "horz_a");
    check("horz_a10_2400", 32'(vram_a10), 0);
    probe(16'h8000, 14'h2800, "horz_b");
    check("horz_a10_2800", 32'(vram_a10), 1);

    // Reset mid-sequence discards partial shift
    bus_write(16'hE000, 8'h01);
    bus_write(16'hE000, 8'h01);
    bus_write(16'hE000, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    probe(16'hC000, 14'h0000, "rst2C000");
    check("rst2_prg_C000", 32'(prg_rom_addr), 32'h3C000);
    load_reg(16'hE000, 5'd1);
    probe(16'h8000, 14'h0000, "prg1");
    check("prg1_8000", 32'(prg_rom_addr), 32'h04000);

    // Writes with cpu_en low are ignored
    for (int i = 0; i < 5; i++) begin
      cpu_en = 1'b0; prg_write = 1'b1; prg_addr = 16'hE000; prg_wdata = 8'h00;
      tick();
    end
    probe(16'h8000, 14'h0000, "noen");
    check("noen_prg_8000", 32'(prg_rom_addr), 32'h04000);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      cpu_en    = ($urandom_range(0, 3) != 0);
      prg_write = ($urandom_range(0, 2) != 0);
      prg_addr  = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) prg_addr[15] = 1'b1;
      prg_wdata = 8'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) prg_wdata[7] = 1'b1;
      chr_addr  = 14'($urandom_range(0, 16383));
      tick();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
